// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive framing path.
package uart_pkg;
   localparam logic [7:0] TERM_DEFAULT    = 8'h0A;
   localparam int         MAX_LEN_DEFAULT = 8;
   localparam int         DEPTH_DEFAULT   = 16;

   typedef enum logic {
      COLLECT = 1'b0,
      DISCARD = 1'b1
   } frame_state_e;
endpackage

// File: rtl/uart_frame_fifo.sv
// Commit/rollback FIFO: bytes become visible to the reader only once committed,
// and an uncommitted tail can be abandoned by pulling wr back to commit.
module uart_frame_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic       clk_3125,
   input  logic       rst,
   input  logic       push,
   input  logic [8:0] push_data,
   input  logic       commit,
   input  logic       rollback,
   input  logic       pop,
   output logic [8:0] rd_data,
   output logic       spec_full,
   output logic       empty_committed
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] ONE     = PW'(1);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   logic [8:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] cm_ptr;
   logic [PW-1:0] rd_ptr;

   assign spec_full       = (wr_ptr - rd_ptr) == DEPTH_P;
   assign empty_committed = (rd_ptr == cm_ptr);
   assign rd_data         = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (rollback) begin
            wr_ptr <= cm_ptr;
         end else if (push) begin
            wr_ptr <= wr_ptr + ONE;
         end
         // commit includes the byte being pushed in the same cycle
         if (commit) begin
            cm_ptr <= push ? (wr_ptr + ONE) : wr_ptr;
         end
         if (pop && !empty_committed) begin
            rd_ptr <= rd_ptr + ONE;
         end
      end
   end

   always_ff @(posedge clk_3125) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_rx byte stream on TERM; only complete, parity-clean,
// length-legal frames reach the command parser, bad ones are dropped and counted.
//   state   | meaning
//   COLLECT | accumulating bytes of the current frame into the FIFO
//   DISCARD | frame dropped, ignoring bytes until a clean TERM resyncs
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int         DEPTH   = DEPTH_DEFAULT,
   parameter int         MAX_LEN = MAX_LEN_DEFAULT,
   parameter logic [7:0] TERM    = TERM_DEFAULT
) (
   input  logic       clk_3125,
   input  logic       rst,
   input  logic [7:0] rx_msg,
   input  logic       parity_error,
   input  logic       rx_complete,
   output logic [7:0] m_data,
   output logic       m_last,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_drop,
   output logic [7:0] drop_cnt,
   output logic       busy
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN - 1);
   localparam logic [LW-1:0] LEN_ONE  = LW'(1);

   frame_state_e  state, state_nxt;
   logic [LW-1:0] len, len_nxt;
   logic          rxc_d;
   logic          stb;
   logic          push, commit, rollback, drop;
   logic [8:0]    push_data;
   logic [8:0]    rd_data;
   logic          spec_full;
   logic          empty_committed;

   assign stb     = rx_complete & ~rxc_d;
   assign m_valid = ~empty_committed;
   assign m_data  = rd_data[7:0];
   assign m_last  = rd_data[8];
   assign busy    = (state == DISCARD) | (len != '0);

   uart_frame_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_3125        (clk_3125),
      .rst             (rst),
      .push            (push),
      .push_data       (push_data),
      .commit          (commit),
      .rollback        (rollback),
      .pop             (m_ready),
      .rd_data         (rd_data),
      .spec_full       (spec_full),
      .empty_committed (empty_committed)
   );

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         state      <= COLLECT;
         len        <= '0;
         rxc_d      <= 1'b0;
         frame_drop <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         state      <= state_nxt;
         len        <= len_nxt;
         rxc_d      <= rx_complete;
         frame_drop <= drop;
         if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      push      = 1'b0;
      push_data = {1'b0, rx_msg};
      commit    = 1'b0;
      rollback  = 1'b0;
      drop      = 1'b0;
      case (state)
         COLLECT: begin
            if (stb) begin
               // parity is checked first so a corrupted TERM still drops
               if (parity_error || spec_full ||
                   (len == LEN_LAST && rx_msg != TERM)) begin
                  rollback  = 1'b1;
                  drop      = 1'b1;
                  len_nxt   = '0;
                  state_nxt = DISCARD;
               end else if (rx_msg == TERM) begin
                  push      = 1'b1;
                  push_data = {1'b1, TERM};
                  commit    = 1'b1;
                  len_nxt   = '0;
               end else begin
                  push    = 1'b1;
                  len_nxt = len + LEN_ONE;
               end
            end
         end
         DISCARD: begin
            if (stb && rx_msg == TERM && !parity_error) begin
               state_nxt = COLLECT;
               len_nxt   = '0;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench: a queue-based frame model predicts the delivered byte stream,
// drop pulses and counter; a negedge monitor compares whatever the DUT presents.
module tb_uart_rx_frame_ctrl;
   localparam int         DEPTH   = 16;
   localparam int         MAX_LEN = 8;
   localparam logic [7:0] TERM    = 8'h0A;

   logic       clk_3125 = 1'b0;
   logic       rst;
   logic [7:0] rx_msg;
   logic       parity_error;
   logic       rx_complete;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_valid;
   logic       m_ready;
   logic       frame_drop;
   logic [7:0] drop_cnt;
   logic       busy;

   always #160 clk_3125 = ~clk_3125;

   uart_rx_frame_ctrl #(
      .DEPTH   (DEPTH),
      .MAX_LEN (MAX_LEN),
      .TERM    (TERM)
   ) dut (
      .clk_3125     (clk_3125),
      .rst          (rst),
      .rx_msg       (rx_msg),
      .parity_error (parity_error),
      .rx_complete  (rx_complete),
      .m_data       (m_data),
      .m_last       (m_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .frame_drop   (frame_drop),
      .drop_cnt     (drop_cnt),
      .busy         (busy)
   );

   int checks = 0;
   int errors = 0;

   // reference model: frames as queues, occupancy as counts
   logic [8:0] sb_q [$];
   logic [7:0] cur_q [$];
   int         m_comm;
   bit         m_disc;
   bit         rxc_prev;
   bit         e_drop;
   int         e_cnt;
   bit         mdl_stb;
   bit         mdl_pop;
   int         occ;

   always @(posedge clk_3125) begin
      if (rst) begin
         sb_q.delete();
         cur_q.delete();
         m_comm   = 0;
         m_disc   = 0;
         rxc_prev = 0;
         e_drop   = 0;
         e_cnt    = 0;
      end else begin
         mdl_stb = rx_complete && !rxc_prev;
         mdl_pop = (m_comm > 0) && m_ready;
         occ     = m_comm + cur_q.size();
         e_drop  = 0;
         if (mdl_stb) begin
            if (!m_disc) begin
               if (parity_error || occ == DEPTH ||
                   (cur_q.size() == MAX_LEN - 1 && rx_msg != TERM)) begin
                  cur_q.delete();
                  m_disc = 1;
                  e_drop = 1;
                  if (e_cnt < 255) e_cnt++;
               end else if (rx_msg == TERM) begin
                  foreach (cur_q[i]) sb_q.push_back({1'b0, cur_q[i]});
                  sb_q.push_back({1'b1, TERM});
                  m_comm += cur_q.size() + 1;
                  cur_q.delete();
               end else begin
                  cur_q.push_back(rx_msg);
               end
            end else if (rx_msg == TERM && !parity_error) begin
               m_disc = 0;
            end
         end
         if (mdl_pop) m_comm--;
         rxc_prev = rx_complete;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   logic [8:0] exp_item;
   always @(negedge clk_3125) begin
      if (!rst) begin
         chk("m_valid", int'(m_valid), int'(m_comm > 0));
         chk("frame_drop", int'(frame_drop), int'(e_drop));
         chk("drop_cnt", int'(drop_cnt), e_cnt);
         chk("busy", int'(busy), int'(m_disc || cur_q.size() != 0));
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", int'({m_last, m_data}), -1);
            end else begin
               exp_item = sb_q.pop_front();
               chk("m_data", int'(m_data), int'(exp_item[7:0]));
               chk("m_last", int'(m_last), int'(exp_item[8]));
            end
         end
      end
   end

   // 0 = hold low, 1 = hold high, 2 = random each cycle
   int ready_mode = 1;
   initial begin
      m_ready = 1'b0;
      forever begin
         @(negedge clk_3125);
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic pe, input int hold);
      rx_msg       = b;
      parity_error = pe;
      rx_complete  = 1'b1;
      repeat (hold) @(negedge clk_3125);
      rx_complete  = 1'b0;
      parity_error = 1'b0;
      @(negedge clk_3125);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      rx_complete = 1'b0;
      repeat (2) @(negedge clk_3125);
      rst = 1'b0;
   endtask

   task automatic drain();
      int n;
      ready_mode = 1;
      n = 0;
      while ((sb_q.size() != 0 || m_comm != 0) && n < 200) begin
         @(negedge clk_3125);
         n++;
      end
      repeat (2) @(negedge clk_3125);
      chk("drain_left", sb_q.size(), 0);
   endtask

   initial begin
      rst          = 1'b1;
      rx_msg       = 8'h00;
      parity_error = 1'b0;
      rx_complete  = 1'b0;
      repeat (3) @(negedge clk_3125);
      rst = 1'b0;
      @(negedge clk_3125);

      // basic frame
      send_byte(8'h41, 0, 1); send_byte(8'h42, 0, 1); send_byte(TERM, 0, 1);
      drain();

      // parity-error frame dropped, next frame survives
      send_byte(8'h41, 0, 1); send_byte(8'h42, 1, 1); send_byte(8'h43, 0, 1);
      send_byte(TERM, 0, 1);  send_byte(8'h55, 0, 1); send_byte(TERM, 0, 1);
      drain();

      // overlength frame
      for (int i = 0; i < MAX_LEN; i++) send_byte(8'h60 + 8'(i), 0, 1);
      send_byte(TERM, 0, 1); send_byte(8'h31, 0, 1); send_byte(TERM, 0, 1);
      drain();

      // FIFO fills with two committed frames, third frame dropped
      ready_mode = 0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < MAX_LEN - 1; i++) send_byte(8'h20 + 8'(i), 0, 1);
         send_byte(TERM, 0, 1);
      end
      send_byte(TERM, 0, 1);
      drain();
      send_byte(TERM, 0, 1);

      // reset mid-frame loses the partial frame
      send_byte(8'h41, 0, 1); send_byte(8'h42, 0, 1);
      do_reset();
      send_byte(TERM, 0, 1);
      drain();

      // held rx_complete, pop coinciding with a commit
      ready_mode = 0;
      send_byte(8'h41, 0, 1); send_byte(TERM, 0, 1);
      ready_mode = 1;
      send_byte(TERM, 0, 3);
      send_byte(8'h77, 0, 2); send_byte(TERM, 0, 1);
      drain();

      // randomized traffic
      ready_mode = 2;
      for (int n = 0; n < 1500; n++) begin
         logic [7:0] b;
         b = ($urandom_range(0, 3) == 0) ? TERM : 8'($urandom_range(0, 255));
         send_byte(b, ($urandom_range(0, 15) == 0), $urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_3125);
         if ($urandom_range(0, 299) == 0) do_reset();
      end
      drain();

      // drop counter saturation
      ready_mode = 2;
      for (int n = 0; n < 260; n++) begin
         send_byte(8'h55, 1, 1);
         send_byte(TERM, 0, 1);
      end
      drain();
      chk("drop_cnt_sat", int'(drop_cnt), 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
